basemul_ctrl: RTL and testbench

Sequencer that drives the pointwise NTT-domain multiplier. It streams all 128 coefficient pairs of two Kyber polynomials (a, b) from pair-wide RAMs into the basemul pipeline, together with the matching zeta (+zetas[64+p/2] for even pair p, negated for odd p). It collects the {t1,t0} results and writes them to the result RAM at the issuing pair's address. It is the memory-side initiator/collector for basemul and runs one full polynomial product per start/done handshake.

---
 rtl/basemul_ctrl.sv | 94 +++++++++
 tb/tb_basemul_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/basemul_ctrl.sv
// basemul_ctrl: streams a/b coefficient pairs and zetas into basemul and writes results back in order
module basemul_ctrl #(
  parameter int BM_LAT = 7,
  parameter int NPAIR  = 128,
  parameter int ZBASE  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        rd_en,
  output logic [6:0]  rd_addr,
  input  logic [31:0] a_rdata,
  input  logic [31:0] b_rdata,
  output logic [6:0]  z_addr,
  input  logic [15:0] z_rdata,
  output logic        bm_set,
  output logic [15:0] bm_a1,
  output logic [15:0] bm_a0,
  output logic [15:0] bm_b1,
  output logic [15:0] bm_b0,
  output logic [15:0] bm_zeta,
  input  logic [15:0] bm_t1,
  input  logic [15:0] bm_t0,
  output logic        r_we,
  output logic [6:0]  r_addr,
  output logic [31:0] r_wdata
);
  localparam int D = 2 + BM_LAT;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
  state_t st;
  logic [D-1:0] sv;
  logic [D-1:0][6:0] sp;
  logic [15:0] zr;
  // odd pairs use the negated zeta; 16-bit wrap keeps -(-32768) at -32768
  assign zr = sp[0][0] ? ~z_rdata + 16'd1 : z_rdata;
  assign r_we = sv[D-1];
  assign r_addr = sp[D-1];
  assign r_wdata = r_we ? {bm_t1, bm_t0} : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      rd_en <= 1'b0;
      bm_set <= 1'b0;
      rd_addr <= '0;
      z_addr <= '0;
      sv <= '0;
      sp <= '0;
      bm_a1 <= '0;
      bm_a0 <= '0;
      bm_b1 <= '0;
      bm_b0 <= '0;
      bm_zeta <= '0;
    end else begin
      sv <= {sv[D-2:0], rd_en};
      sp <= {sp[D-2:0], rd_addr};
      done <= 1'b0;
      if (sv[0]) begin
        bm_a1 <= a_rdata[31:16];
        bm_a0 <= a_rdata[15:0];
        bm_b1 <= b_rdata[31:16];
        bm_b0 <= b_rdata[15:0];
        bm_zeta <= zr;
      end
      case (st)
        IDLE: if (start) begin
          st <= ISSUE;
          busy <= 1'b1;
          bm_set <= 1'b1;
          rd_en <= 1'b1;
          rd_addr <= '0;
          z_addr <= 7'(ZBASE);
        end
        ISSUE: if (rd_addr == 7'(NPAIR - 1)) begin
          rd_en <= 1'b0;
          st <= DRAIN;
        end else begin
          rd_addr <= rd_addr + 7'd1;
          z_addr <= 7'(ZBASE) + ((rd_addr + 7'd1) >> 1);
        end
        DRAIN: if (sv == '0) begin
          st <= FIN;
          done <= 1'b1;
          busy <= 1'b0;
          bm_set <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_basemul_ctrl.sv
// tb_basemul_ctrl: RAM/ROM stubs plus a BM_LAT-deep basemul stand-in, with a write scoreboard
module tb_basemul_ctrl;
  localparam int BM_LAT = 7;
  localparam int ZBASE = 64;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy, done, rd_en, bm_set, r_we;
  logic [6:0] rd_addr, z_addr, r_addr;
  logic [31:0] a_rdata, b_rdata, r_wdata;
  logic [15:0] z_rdata, bm_a1, bm_a0, bm_b1, bm_b0, bm_zeta, bm_t1, bm_t0;
  logic [31:0] amem [128];
  logic [31:0] bmem [128];
  logic [15:0] zrom [128];
  logic [31:0] pipe [BM_LAT];
  logic [38:0] sbq [$];
  int checks = 0, errors = 0;

  basemul_ctrl #(.BM_LAT(BM_LAT), .NPAIR(128), .ZBASE(ZBASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .z_addr(z_addr), .z_rdata(z_rdata), .bm_set(bm_set),
    .bm_a1(bm_a1), .bm_a0(bm_a0), .bm_b1(bm_b1), .bm_b0(bm_b0), .bm_zeta(bm_zeta),
    .bm_t1(bm_t1), .bm_t0(bm_t0), .r_we(r_we), .r_addr(r_addr), .r_wdata(r_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] zexp(input int p);
    logic [15:0] z = zrom[ZBASE + p / 2];
    return (p % 2 == 1) ? 16'h0000 - z : z;
  endfunction

  function automatic logic [31:0] bm_ref(input int p);
    logic [15:0] z = zexp(p);
    logic [15:0] t1 = amem[p][31:16] + bmem[p][31:16] + z;
    logic [15:0] t0 = amem[p][15:0] - bmem[p][15:0];
    return {t1, t0};
  endfunction

  always @(posedge clk) if (rd_en) begin
    a_rdata <= amem[rd_addr];
    b_rdata <= bmem[rd_addr];
    z_rdata <= zrom[z_addr];
  end

  always @(posedge clk) begin
    pipe[0] <= {bm_a1 + bm_b1 + bm_zeta, bm_a0 - bm_b0};
    for (int i = 1; i < BM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {bm_t1, bm_t0} = pipe[BM_LAT-1];

  always @(posedge clk) if (rst_n && rd_en) sbq.push_back({rd_addr, bm_ref(int'(rd_addr))});

  task automatic reset_chk();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_bm_set", bm_set, 0);
    chk("rst_r_we", r_we, 0);
    chk("rst_addrs", {rd_addr, z_addr, r_addr}, 0);
    chk("rst_r_wdata", r_wdata, 0);
    chk("rst_ops", {bm_a1, bm_a0, bm_b1, bm_b0}, 0);
    chk("rst_zeta", bm_zeta, 0);
  endtask

  task automatic run_mon(input bit hold);
    int nw = 0;
    logic [38:0] e;
    for (int n = 1; n <= 140; n++) begin
      if (n == 1 && !hold) start = 1'b0;
      chk("busy", busy, n <= 138);
      chk("done", done, n == 139);
      chk("rd_en", rd_en, n <= 128);
      chk("bm_set", bm_set, n <= 138);
      if (rd_en) begin
        chk("rd_addr", rd_addr, n - 1);
        chk("z_addr", z_addr, ZBASE + (n - 1) / 2);
      end
      if (n >= 3 && n <= 130) chk("bm_zeta", bm_zeta, zexp(n - 3));
      chk("r_we", r_we, n >= 10 && n <= 137);
      if (r_we) begin
        nw++;
        if (sbq.size() == 0) chk("sb_empty", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("r_addr", r_addr, e[38:32]);
          chk("r_wdata", r_wdata, e[31:0]);
        end
      end
      if (n < 140) begin
        @(posedge clk);
        #1;
      end
    end
    chk("n_writes", nw, 128);
  endtask

  initial begin
    int stray;
    for (int p = 0; p < 128; p++) begin
      amem[p] = {16'(p), 16'(p)};
      bmem[p] = $urandom;
      zrom[p] = 16'($urandom);
    end
    zrom[64] = 16'h0100;
    zrom[65] = 16'h8000;
    repeat (3) @(posedge clk);
    #1;
    reset_chk();
    @(negedge clk) rst_n = 1'b1;
    // start held across the whole run and through done: one extra IDLE cycle, then a second run
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    run_mon(1'b1);
    @(posedge clk);
    #1;
    run_mon(1'b0);
    chk("sb_drained", sbq.size(), 0);
    // asynchronous reset in the middle of a run
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (59) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    reset_chk();
    sbq.delete();
    stray = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (r_we) stray++;
    end
    chk("no_write_in_reset", stray, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int p = 0; p < 128; p++) begin
      amem[p] = $urandom;
      bmem[p] = $urandom;
      zrom[p] = 16'($urandom);
    end
    zrom[100] = 16'h8000;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    run_mon(1'b0);
    chk("sb_drained2", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
